// File: rtl/conv_job_ctrl_if.sv
// conv_job_ctrl_if
//   Groups the shared weight/data source handshake and the bus towards the
//   convolution core.
//   slave  : controller view (consumes src_*, res_ready; drives src_ready
//            and the conv_* / *_valid signals).
//   master : environment view (source plus convolution core).
interface conv_job_ctrl_if #(
   parameter int DataWidth   = 64,
   parameter int InputDim    = 4,
   parameter int MaxRowWidth = 9,
   parameter int MaxColWidth = 9
);
   logic [InputDim*DataWidth-1:0] src_data;
   logic                          src_valid;
   logic                          src_ready;
   logic                          conv_rst;
   logic [MaxRowWidth-1:0]        conv_row;
   logic [MaxColWidth-1:0]        conv_col;
   logic [InputDim*DataWidth-1:0] conv_bus;
   logic                          weight_valid;
   logic                          data_valid;
   logic                          res_ready;

   modport slave (
      input  src_data, src_valid, res_ready,
      output src_ready, conv_rst, conv_row, conv_col, conv_bus,
             weight_valid, data_valid
   );

   modport master (
      output src_data, src_valid, res_ready,
      input  src_ready, conv_rst, conv_row, conv_col, conv_bus,
             weight_valid, data_valid
   );
endinterface

// File: rtl/conv_job_ctrl.sv
// conv_job_ctrl
//   Job sequencer in front of the convolution core. One job per start:
//   pulse the core's synchronous reset, stream KernelSize weight beats and
//   then row*col data beats from a shared valid/ready source, then count
//   result beats against the expected valid-convolution output count.
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   start             job request (sampled in IDLE only)
//   row_cfg, col_cfg  image dimensions for the job
//   bus (slave)       source handshake and core-facing bus
//   res_count         result beats counted this job
//   busy, done, err   status: not idle, one-cycle completion, sticky error
module conv_job_ctrl #(
   parameter int DataWidth     = 64,
   parameter int InputDim      = 4,
   parameter int KernelSize    = 9,
   parameter int KernelDim     = 3,
   parameter int MaxRowWidth   = 9,
   parameter int MaxColWidth   = 9,
   parameter int MaxDim        = 416,
   parameter int RstCycles     = 4,
   parameter int TimeoutCycles = 4096
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   start,
   input  logic [MaxRowWidth-1:0] row_cfg,
   input  logic [MaxColWidth-1:0] col_cfg,
   conv_job_ctrl_if.slave         bus,
   output logic [17:0]            res_count,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int BeatW = InputDim * DataWidth;
   localparam int RcW   = $clog2(RstCycles + 1);
   localparam int ToW   = $clog2(TimeoutCycles + 1);

   localparam logic [MaxRowWidth-1:0] RowMin = MaxRowWidth'(KernelDim);
   localparam logic [MaxRowWidth-1:0] RowMax = MaxRowWidth'(MaxDim);
   localparam logic [MaxRowWidth-1:0] RowKm1 = MaxRowWidth'(KernelDim - 1);
   localparam logic [MaxColWidth-1:0] ColMin = MaxColWidth'(KernelDim);
   localparam logic [MaxColWidth-1:0] ColMax = MaxColWidth'(MaxDim);
   localparam logic [MaxColWidth-1:0] ColKm1 = MaxColWidth'(KernelDim - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_LDW, S_LDD, S_DRAIN, S_DONE
   } state_t;

   state_t                 r_state, w_next_state;
   logic [RcW-1:0]         r_rst_cnt;
   logic [17:0]            r_beat_cnt;
   logic [17:0]            r_total;
   logic [17:0]            r_exp;
   logic [17:0]            r_res_cnt;
   logic [ToW-1:0]         r_idle_cnt;
   logic                   r_err;
   logic [BeatW-1:0]       r_conv_bus;
   logic                   r_weight_valid;
   logic                   r_data_valid;
   logic [MaxRowWidth-1:0] r_conv_row;
   logic [MaxColWidth-1:0] r_conv_col;

   logic        w_cfg_bad, w_in_ldw, w_in_ldd, w_in_drain, w_src_ready, w_accept;
   logic        w_last_w, w_last_d, w_res_en, w_res_over, w_timeout;
   logic [17:0] w_res_inc, w_exp, w_total;

   assign w_cfg_bad = (row_cfg < RowMin) || (row_cfg > RowMax) ||
                      (col_cfg < ColMin) || (col_cfg > ColMax);
   // Valid-convolution output count and input beat count, latched at start.
   assign w_exp   = 18'(row_cfg - RowKm1) * 18'(col_cfg - ColKm1);
   assign w_total = 18'(row_cfg) * 18'(col_cfg);

   // Moore decodes of the state register.
   assign w_in_ldw    = (r_state == S_LDW);
   assign w_in_ldd    = (r_state == S_LDD);
   assign w_in_drain  = (r_state == S_DRAIN);
   assign w_src_ready = w_in_ldw || w_in_ldd;
   assign w_accept    = bus.src_valid && w_src_ready;

   assign w_last_w   = (r_beat_cnt == 18'(KernelSize - 1));
   assign w_last_d   = (r_beat_cnt == (r_total - 18'd1));
   // Results are only meaningful while data is flowing or draining.
   assign w_res_en   = bus.res_ready && (w_in_ldd || w_in_drain);
   assign w_res_inc  = r_res_cnt + 18'd1;
   assign w_res_over = w_res_en && (r_res_cnt == r_exp);
   assign w_timeout  = w_in_drain && !bus.res_ready &&
                       (r_idle_cnt == ToW'(TimeoutCycles - 1));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples pre-edge values regardless of statement order.
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: default first, so no branch can leave w_next_state unassigned
      // and infer a latch.
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:  if (start && !w_cfg_bad) w_next_state = S_CLR;
         S_CLR:   if (r_rst_cnt == RcW'(RstCycles - 1)) w_next_state = S_LDW;
         S_LDW:   if (w_accept && w_last_w) w_next_state = S_LDD;
         S_LDD: begin
            if (w_res_over)               w_next_state = S_IDLE;
            else if (w_accept && w_last_d) w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            // The final result moves straight to DONE so done lands one
            // cycle after it; results that all arrived during LDD are
            // caught on the first DRAIN cycle.
            if (w_res_over || w_timeout) w_next_state = S_IDLE;
            else if ((r_res_cnt == r_exp) || (w_res_en && (w_res_inc == r_exp)))
               w_next_state = S_DONE;
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_rst_cnt      <= '0;
         r_beat_cnt     <= '0;
         r_total        <= '0;
         r_exp          <= '0;
         r_res_cnt      <= '0;
         r_idle_cnt     <= '0;
         r_err          <= 1'b0;
         r_conv_bus     <= '0;
         r_weight_valid <= 1'b0;
         r_data_valid   <= 1'b0;
         r_conv_row     <= '0;
         r_conv_col     <= '0;
      end else begin
         r_weight_valid <= w_accept && w_in_ldw;
         r_data_valid   <= w_accept && w_in_ldd;
         if (w_accept) r_conv_bus <= bus.src_data;

         if (r_state == S_IDLE && start) begin
            r_conv_row <= row_cfg;
            r_conv_col <= col_cfg;
            r_err      <= w_cfg_bad;
            r_rst_cnt  <= '0;
            r_beat_cnt <= '0;
            r_res_cnt  <= '0;
            r_exp      <= w_exp;
            r_total    <= w_total;
         end

         if (r_state == S_CLR) r_rst_cnt <= r_rst_cnt + RcW'(1);

         // One counter serves both phases; it wraps at each phase boundary.
         if (w_accept) begin
            if ((w_in_ldw && w_last_w) || (w_in_ldd && w_last_d)) r_beat_cnt <= '0;
            else                                                  r_beat_cnt <= r_beat_cnt + 18'd1;
         end

         if (w_res_en && !w_res_over) r_res_cnt <= w_res_inc;
         if (w_res_over || w_timeout) r_err <= 1'b1;

         if (w_in_drain && !bus.res_ready) r_idle_cnt <= r_idle_cnt + ToW'(1);
         else                              r_idle_cnt <= '0;
      end
   end

   assign bus.src_ready    = w_src_ready;
   assign bus.conv_rst     = (r_state == S_CLR);
   assign bus.conv_row     = r_conv_row;
   assign bus.conv_col     = r_conv_col;
   assign bus.conv_bus     = r_conv_bus;
   assign bus.weight_valid = r_weight_valid;
   assign bus.data_valid   = r_data_valid;
   assign res_count        = r_res_count_out();
   assign busy             = (r_state != S_IDLE);
   assign done             = (r_state == S_DONE);
   assign err              = r_err;

   function automatic logic [17:0] r_res_count_out();
      return r_res_cnt;
   endfunction

endmodule

// File: tb/tb_conv_job_ctrl.sv
// tb_conv_job_ctrl
//   Self-checking bench for conv_job_ctrl: a configuration table, directed
//   jobs (continuous, toggled valid, result overflow, drain timeout, reset
//   mid-stream) and random jobs, all compared cycle by cycle against a
//   job-level model built from beat and result counts.
module tb_conv_job_ctrl;

   localparam int DW       = 64;
   localparam int ID       = 4;
   localparam int BW       = DW * ID;
   localparam int KS       = 9;
   localparam int KD       = 3;
   localparam int RST      = 4;
   localparam int TO       = 4096;
   localparam int JobLimit = 6000;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        start;
   logic [8:0]  row_cfg;
   logic [8:0]  col_cfg;
   logic [17:0] res_count;
   logic        busy, done, err;

   int n_checks = 0;
   int n_errors = 0;

   conv_job_ctrl_if #(.DataWidth(DW), .InputDim(ID), .MaxRowWidth(9), .MaxColWidth(9)) bus ();

   conv_job_ctrl dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .start     (start),
      .row_cfg   (row_cfg),
      .col_cfg   (col_cfg),
      .bus       (bus.slave),
      .res_count (res_count),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_src_ready"},    bus.src_ready,    0);
      check({tag, "_conv_rst"},     bus.conv_rst,     0);
      check({tag, "_weight_valid"}, bus.weight_valid, 0);
      check({tag, "_data_valid"},   bus.data_valid,   0);
      check({tag, "_conv_bus"},     bus.conv_bus,     0);
      check({tag, "_conv_row"},     bus.conv_row,     0);
      check({tag, "_conv_col"},     bus.conv_col,     0);
      check({tag, "_res_count"},    res_count,        0);
      check({tag, "_busy"},         busy,             0);
      check({tag, "_done"},         done,             0);
      check({tag, "_err"},          err,              0);
   endtask

   // One complete job. Cycle k is the k-th cycle after start was sampled.
   // vmode: 0 continuous valid, 1 toggled valid, 2 random valid (plus
   //        stray start pulses that must be ignored)
   // rmode: 0 results back-to-back in drain, 1 random results from the
   //        data phase on, 2 results every cycle (overflow), 3 no results
   task automatic do_job(input int row, input int col, input int vmode, input int rmode);
      int n, e, tot, acc, res, c_rel, r_rel, done_k, err_k, prev_idx;
      bit prev_acc, acc_now, sv, rr, counted, fin;
      logic [BW-1:0] prev_beat, beat;
      n = row * col;
      e = (row - KD + 1) * (col - KD + 1);
      tot = KS + n;
      acc = 0; res = 0; c_rel = 0; r_rel = 0; done_k = 0; err_k = 0;
      prev_idx = 0; prev_acc = 1'b0; fin = 1'b0; prev_beat = '0; beat = '0;
      @(negedge Clk);
      row_cfg = 9'(row); col_cfg = 9'(col); start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      for (int k = 1; k <= JobLimit && !fin; k++) begin
         if (err_k != 0 && k == err_k) begin
            check("err_rise",      err,           1);
            check("err_busy",      busy,          0);
            check("err_src_ready", bus.src_ready, 0);
            check("err_no_done",   done,          0);
            fin = 1'b1;
         end else if (done_k != 0 && k == done_k + 1) begin
            check("end_busy",      busy,      0);
            check("end_done",      done,      0);
            check("end_err",       err,       0);
            check("end_res_count", res_count, 18'(e));
            fin = 1'b1;
         end else begin
            check("conv_rst",     bus.conv_rst,     k <= RST);
            check("src_ready",    bus.src_ready,    (k > RST) && (acc < tot));
            check("weight_valid", bus.weight_valid, prev_acc && (prev_idx < KS));
            check("data_valid",   bus.data_valid,   prev_acc && (prev_idx >= KS));
            if (prev_acc) check("conv_bus", bus.conv_bus, prev_beat);
            check("conv_row", bus.conv_row, row);
            check("conv_col", bus.conv_col, col);
            check("busy", busy, 1);
            check("err",  err,  0);
            check("done", done, (done_k != 0) && (k == done_k));
            if (done_k != 0 && k == done_k) check("done_res_count", res_count, 18'(e));
         end
         if (!fin) begin
            case (vmode)
               0:       sv = 1'b1;
               1:       sv = k[0];
               default: sv = ($urandom_range(0, 2) != 0);
            endcase
            for (int i = 0; i < BW / 32; i++) beat[i*32 +: 32] = $urandom;
            acc_now = sv && (k > RST) && (acc < tot);
            counted = (acc >= KS) && (done_k == 0);
            case (rmode)
               0:       rr = counted && (acc == tot) && (res < e);
               1:       rr = counted && (res < e) && ($urandom_range(0, 2) == 0);
               2:       rr = counted;
               default: rr = 1'b0;
            endcase
            if (rr) begin
               if (res == e) err_k = k + 1;
               else begin
                  res++;
                  if (res == e) r_rel = k;
               end
            end
            if (acc_now) begin
               prev_idx = acc;
               acc++;
               if (acc == tot) c_rel = k;
            end
            prev_acc  = acc_now;
            prev_beat = beat;
            if (rmode == 3 && c_rel != 0 && err_k == 0) err_k = c_rel + 1 + TO;
            if (rmode != 2 && done_k == 0 && res == e && c_rel != 0)
               done_k = ((r_rel > c_rel + 1) ? r_rel : c_rel + 1) + 1;
            bus.src_valid = sv;
            bus.src_data  = beat;
            bus.res_ready = rr;
            start = (vmode == 2) && ($urandom_range(0, 7) == 0);
            if (start) begin
               row_cfg = 9'($urandom_range(3, 9));
               col_cfg = 9'($urandom_range(3, 9));
            end
            @(negedge Clk);
         end
      end
      check("job_bound", fin, 1);
      start = 1'b0;
      bus.src_valid = 1'b0;
      bus.res_ready = 1'b0;
   endtask

   typedef struct {
      int row;
      int col;
      bit exp_err;
   } cfg_vec_t;

   cfg_vec_t vecs[10];

   initial begin
      vecs = '{'{2, 5, 1'b1}, '{3, 3, 1'b0}, '{5, 2, 1'b1}, '{416, 416, 1'b0},
               '{417, 5, 1'b1}, '{3, 416, 1'b0}, '{5, 417, 1'b1}, '{0, 0, 1'b1},
               '{511, 3, 1'b1}, '{2, 5, 1'b1}};
      Rst_n = 1'b0; start = 1'b0; row_cfg = '0; col_cfg = '0;
      bus.src_valid = 1'b0; bus.src_data = '0; bus.res_ready = 1'b0;
      #12;
      check_zero("por");
      @(negedge Clk);
      Rst_n = 1'b1;

      // Configuration acceptance table.
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         row_cfg = 9'(vecs[i].row); col_cfg = 9'(vecs[i].col); start = 1'b1;
         @(negedge Clk);
         start = 1'b0; bus.src_valid = 1'b1;
         check("cfg_err",       err,           vecs[i].exp_err);
         check("cfg_busy",      busy,          !vecs[i].exp_err);
         check("cfg_conv_rst",  bus.conv_rst,  !vecs[i].exp_err);
         check("cfg_src_ready", bus.src_ready, 0);
         check("cfg_conv_row",  bus.conv_row,  vecs[i].row);
         check("cfg_conv_col",  bus.conv_col,  vecs[i].col);
         if (vecs[i].exp_err) begin
            @(negedge Clk);
            check("cfg_err_hold",      err,           1);
            check("cfg_err_busy",      busy,          0);
            check("cfg_err_src_ready", bus.src_ready, 0);
         end else begin
            #1 Rst_n = 1'b0;
            #1 Rst_n = 1'b1;
         end
         bus.src_valid = 1'b0;
      end

      do_job(5, 5, 0, 0);
      do_job(5, 5, 1, 0);
      do_job(4, 4, 0, 2);
      do_job(4, 4, 0, 3);
      for (int j = 0; j < 6; j++)
         do_job(int'($urandom_range(3, 8)), int'($urandom_range(3, 8)), 2, 1);

      // Reset in the middle of the data phase.
      @(negedge Clk);
      row_cfg = 9'd5; col_cfg = 9'd5; start = 1'b1;
      @(negedge Clk);
      start = 1'b0; bus.src_valid = 1'b1;
      repeat (16) @(negedge Clk);
      check("pre_rst_data_valid", bus.data_valid, 1);
      #2 Rst_n = 1'b0;
      #1;
      check_zero("mid_ldd");
      @(negedge Clk);
      bus.src_valid = 1'b0;
      Rst_n = 1'b1;
      do_job(5, 5, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
